mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage initiator for the word-wide data RAM: accepts one load/store per request from EX/MEM, drives memRead/memWrite, waits on rdy.
//  Adds byte/halfword access: sign/zero-extended sub-word loads; sub-word stores by read-modify-write.
//  Stalls the pipeline until the access completes. Flags misalignment and a missing rdy (watchdog).
// PARAMETERS
//  ADDR_W   11   RAM word-address width; mem_addr = req_addr[ADDR_W+1:2]
//  TIMEOUT  15   max cycles in a read state without mem_rdy before timeout_err (>=2)
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   asynchronous, active-high reset
//  req_valid     in   1   access request from EX/MEM
//  req_ready     out  1   1 only in IDLE; request accepted when req_valid&&req_ready
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1   loads: 1 zero-extend, 0 sign-extend
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-aligned
//  resp_valid    out  1   one-cycle completion pulse
//  resp_rdata    out  32  load result, valid with resp_valid (0 for stores/errors)
//  misalign_err  out  1   with resp_valid: access rejected, no RAM cycle issued
//  timeout_err   out  1   with resp_valid: mem_rdy never arrived
//  stall         out  1   hold upstream pipeline; 1 from cycle after accept until resp_valid cycle exclusive
//  mem_addr      out  ADDR_W  RAM word address (registered at accept)
//  mem_wdata     out  32  to RAM data_in
//  mem_rdata     in   32  from RAM data_out; ignored (may be Z) unless mem_rdy=1
//  mem_read      out  1   to RAM memRead
//  mem_write     out  1   to RAM memWrite
//  mem_rdy       in   1   from RAM rdy
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0 except req_ready=1; captured request regs, watchdog cleared. Reset mid-access drops mem_read/mem_write at once; write may be lost.
//  Request regs (we,size,unsigned,addr,wdata) captured at accept; inputs ignored afterwards.
//  Little-endian lanes: byte lane = addr[1:0], half lane = addr[1]. Misaligned: half with addr[0]=1, word with addr[1:0]!=0, size 11.
//  FSM: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
//   IDLE: accept -> misaligned ? RESP(misalign_err) : load ? RD : word store ? WR : RMW_RD.
//   RD/RMW_RD: mem_read=1 held until mem_rdy=1 sampled; that cycle capture mem_rdata. RD -> RESP; RMW_RD -> RMW_WR.
//   WR: mem_write=1, mem_wdata=req_wdata, one cycle -> RESP.
//   RMW_WR: mem_write=1, mem_wdata=captured word with selected lane(s) replaced by wdata[7:0]/[15:0] -> RESP.
//   RESP: resp_valid=1 one cycle, error flags/rdata valid -> IDLE.
//  mem_read and mem_write never both 1; both decoded from state only.
//  Watchdog: counts consecutive RD/RMW_RD cycles with mem_rdy=0; at TIMEOUT -> RESP with timeout_err, no write issued.
//  Latency accept->resp_valid (zero-wait RAM): load 3, word store 2, sub-word store 4, misaligned 1.
//  Load extract: byte/half shifted to bit 0, extended per req_unsigned; word passes through.
//  mem_rdy=1 outside read states is ignored.
// STRUCTURE
//  Include file mem_ctrl_defs.vh: SIZE_BYTE/HALF/WORD codes, state encodings.
//  Sub-module mem_lane_align (combinational): load extract/extend and store merge from (size, addr[1:0], unsigned).
//  FSM, request regs, watchdog in mem_access_ctrl.
// TESTING
//  Zero-wait RAM model matching memRead/rdy timing; X/Z on mem_rdata when rdy=0.
//  Word store 0xDEADBEEF @0x10, then word load @0x10 -> mem_write one cycle at addr 4; resp_rdata=0xDEADBEEF 3 cycles after accept.
//  Byte load signed @0x13 of 0x80FF0011 -> 0xFFFFFF80; unsigned -> 0x00000080; half signed @0x12 -> 0xFFFF80FF.
//  Byte store 0xAB @0x11 over 0x11223344 -> RMW sequence, RAM word 0x1122AB44, resp_valid 4 cycles after accept.
//  Half load @0x01 / size 11 -> resp_valid+misalign_err next cycle, mem_read/mem_write never asserted.
//  RAM holds rdy=0 -> timeout_err after TIMEOUT cycles, no mem_write; then normal load succeeds.
//  rst asserted during RMW_RD -> mem_read 0 same cycle, req_ready=1, no write issued.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: access size codes, FSM states and alignment rule for the MEM-stage controller
package mem_access_ctrl_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SIZE_HALF) ? off[0] : (size == SIZE_WORD) ? |off : (size != SIZE_BYTE);
  endfunction
endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// mem_access_ctrl_lane_align: little-endian sub-word load extract/extend and store lane merge
module mem_access_ctrl_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);
  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] mask;
  // byte offset becomes a bit shift; the mask confines the store to the addressed lane(s)
  always_comb begin
    sh = {off, 3'b000};
    lane = word >> sh;
    mask = ((size == SIZE_BYTE) ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    load_data = (size == SIZE_BYTE) ? {{24{~uns & lane[7]}}, lane[7:0]}
              : (size == SIZE_HALF) ? {{16{~uns & lane[15]}}, lane[15:0]} : word;
    store_word = (size == SIZE_WORD) ? wdata : (word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store initiator with sub-word RMW, misalign check and rdy watchdog
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              misalign_err,
  output logic              timeout_err,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_rdy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t            state_q, state_d;
  logic              we_q, we_d, uns_q, uns_d, mis_q, mis_d, to_q, to_d;
  logic [1:0]        size_q, size_d, off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       load_data, store_word;
  logic              unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  mem_access_ctrl_lane_align u_align (
    .size      (size_q),
    .off       (off_q),
    .uns       (uns_q),
    .word      (data_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .store_word(store_word)
  );
  // next state, request capture at accept, read-data capture on rdy, and the no-rdy watchdog
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    size_d = size_q;
    uns_d = uns_q;
    off_d = off_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    data_d = data_q;
    mis_d = mis_q;
    to_d = to_q;
    cnt_d = '0;
    case (state_q)
      S_IDLE: if (req_valid) begin
        we_d = req_we;
        size_d = req_size;
        uns_d = req_unsigned;
        off_d = req_addr[1:0];
        addr_d = req_addr[ADDR_W+1:2];
        wdata_d = req_wdata;
        mis_d = misaligned(req_size, req_addr[1:0]);
        to_d = 1'b0;
        state_d = mis_d ? S_RESP : !req_we ? S_RD : (req_size == SIZE_WORD) ? S_WR : S_RMW_RD;
      end
      S_RD, S_RMW_RD: if (mem_rdy) begin
        data_d = mem_rdata;
        state_d = (state_q == S_RD) ? S_RESP : S_RMW_WR;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        to_d = 1'b1;
        state_d = S_RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      S_WR, S_RMW_WR: state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  // state and captured-request registers; reset abandons any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q <= 1'b0;
      size_q <= '0;
      uns_q <= 1'b0;
      off_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      data_q <= '0;
      mis_q <= 1'b0;
      to_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      size_q <= size_d;
      uns_q <= uns_d;
      off_q <= off_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      data_q <= data_d;
      mis_q <= mis_d;
      to_q <= to_d;
      cnt_q <= cnt_d;
    end
  end
  assign req_ready = state_q == S_IDLE;
  assign resp_valid = state_q == S_RESP;
  assign stall = !(req_ready || resp_valid);
  assign resp_rdata = (resp_valid && !we_q && !mis_q && !to_q) ? load_data : '0;
  assign misalign_err = resp_valid && mis_q;
  assign timeout_err = resp_valid && to_q;
  assign mem_addr = addr_q;
  assign mem_read = (state_q == S_RD) || (state_q == S_RMW_RD);
  assign mem_write = (state_q == S_WR) || (state_q == S_RMW_WR);
  assign mem_wdata = mem_write ? store_word : '0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed table, timeout/reset sequences and random traffic against a byte-array model
module tb_mem_access_ctrl;
  localparam int ADDR_W = 11;
  localparam int TIMEOUT = 15;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, misalign_err, timeout_err, stall, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_rdy = 1'b0, hold_rdy = 1'b0, preload = 1'b0;
  logic [31:0] ram [2048];
  logic [7:0] mb [8192];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misalign_err(misalign_err),
    .timeout_err(timeout_err), .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_read(mem_read), .mem_write(mem_write), .mem_rdy(mem_rdy)
  );

  function automatic logic [31:0] seed(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h0F1E2D3C;
  endfunction

  // RAM: rdy one cycle after memRead is seen, data driven only while rdy
  always @(posedge clk or posedge rst) begin
    if (rst) mem_rdy <= 1'b0;
    else begin
      if (preload) for (int i = 0; i < 2048; i++) ram[i] <= seed(i);
      else if (mem_write) ram[mem_addr] <= mem_wdata;
      mem_rdy <= mem_read && !mem_rdy && !hold_rdy;
    end
  end
  assign mem_rdata = mem_rdy ? ram[mem_addr] : 32'hzzzz_zzzz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns, input logic [31:0] a);
    int n = nbytes(size);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(mb[(a + k) & 32'h1FFF]) << (8 * k));
    if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic m_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < nbytes(size); k++) mb[(a + k) & 32'h1FFF] = d[8*k +: 8];
  endtask

  function automatic logic m_mis(input logic [1:0] size, input logic [31:0] a);
    return size == 2'd3 || (size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'd0);
  endfunction

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata, input int exp_lat, input logic [31:0] exp_rdata,
                         input logic exp_mis, input logic exp_to, input string tag);
    int lat, wr_cnt;
    logic rd_seen, both, stall_bad;
    logic [ADDR_W-1:0] wr_addr;
    logic exp_w;
    exp_w = we && !exp_mis && !exp_to;
    chk({tag, "/ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1; wr_cnt = 0; rd_seen = 1'b0; both = 1'b0; stall_bad = 1'b0; wr_addr = '0;
    while (!resp_valid && lat < 60) begin
      if (mem_read) rd_seen = 1'b1;
      if (mem_write) begin wr_cnt++; wr_addr = mem_addr; end
      both = both | (mem_read & mem_write);
      if (!stall) stall_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/rdata"}, resp_rdata, exp_rdata);
    chk({tag, "/misalign_err"}, 32'(misalign_err), 32'(exp_mis));
    chk({tag, "/timeout_err"}, 32'(timeout_err), 32'(exp_to));
    chk({tag, "/stall_at_resp"}, 32'(stall), 32'd0);
    chk({tag, "/stall_gap"}, 32'(stall_bad), 32'd0);
    chk({tag, "/rd_wr_overlap"}, 32'(both), 32'd0);
    chk({tag, "/write_cycles"}, 32'(wr_cnt), 32'(exp_w));
    if (exp_w) chk({tag, "/write_addr"}, 32'(wr_addr), 32'(addr[ADDR_W+1:2]));
    if (exp_mis) chk({tag, "/mis_no_read"}, 32'(rd_seen), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic model_req(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                           input logic [31:0] wdata, input string tag);
    logic mis, to;
    int lat;
    logic [31:0] exp;
    mis = m_mis(size, addr);
    to = !mis && hold_rdy && !(we && size == 2'd2);
    lat = mis ? 1 : to ? TIMEOUT + 1 : !we ? 3 : size == 2'd2 ? 2 : 4;
    exp = (!mis && !to && !we) ? m_load(size, uns, addr) : 32'd0;
    run_req(we, size, uns, addr, wdata, lat, exp, mis, to, tag);
    if (we && !mis && !to) m_store(size, addr, wdata);
  endtask

  typedef struct {
    logic we; logic [1:0] size; logic uns; logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] exp_rdata; logic exp_mis; int exp_lat;
  } vec_t;
  vec_t tbl [16];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF0011, 32'h0, 1'b0, 2};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 3};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0, 3};
    tbl[5]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 3};
    tbl[6]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h000080FF, 1'b0, 3};
    tbl[7]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 2};
    tbl[8]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFFAB, 32'h0, 1'b0, 4};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1122AB44, 1'b0, 3};
    tbl[10] = '{1'b0, 2'd1, 1'b0, 32'h01, 32'h0, 32'h0, 1'b1, 1};
    tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1};
    tbl[12] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h1234BEEF, 32'h0, 1'b0, 4};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hBEEFAB44, 1'b0, 3};
    tbl[14] = '{1'b1, 2'd2, 1'b0, 32'h12, 32'h55555555, 32'h0, 1'b1, 1};
    tbl[15] = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h00000044, 1'b0, 3};
    for (int i = 0; i < 2048; i++) begin
      logic [31:0] w;
      w = seed(i);
      for (int k = 0; k < 4; k++) mb[4*i+k] = w[8*k +: 8];
    end
    #12;
    chk("reset/req_ready", 32'(req_ready), 32'd1);
    chk("reset/resp_valid", 32'(resp_valid), 32'd0);
    chk("reset/stall", 32'(stall), 32'd0);
    chk("reset/mem_read", 32'(mem_read), 32'd0);
    chk("reset/mem_write", 32'(mem_write), 32'd0);
    chk("reset/mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
    for (int i = 0; i < 16; i++) begin
      run_req(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, tbl[i].exp_lat,
              tbl[i].exp_rdata, tbl[i].exp_mis, 1'b0, $sformatf("vec%0d", i));
      if (tbl[i].we && !tbl[i].exp_mis) m_store(tbl[i].size, tbl[i].addr, tbl[i].wdata);
    end
    hold_rdy = 1'b1;
    model_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, "timeout_load");
    model_req(1'b1, 2'd0, 1'b0, 32'h41, 32'h000000EE, "timeout_rmw");
    hold_rdy = 1'b0;
    model_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, "after_timeout");
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h44; req_wdata = 32'hCD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_rmw/mem_read_before", 32'(mem_read), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_rmw/mem_read", 32'(mem_read), 32'd0);
    chk("rst_rmw/mem_write", 32'(mem_write), 32'd0);
    chk("rst_rmw/req_ready", 32'(req_ready), 32'd1);
    chk("rst_rmw/stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("rst_rmw/mem_write_held", 32'(mem_write), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    model_req(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, "rst_rmw/word_intact");
    for (int i = 0; i < 200; i++) begin
      model_req(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 255)), $urandom,
                $sformatf("rand%0d", i));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
